input_irq_ctrl: RTL and testbench

- Upstream feeder of the multicycle control FSM's input-interrupt path.
- Buffers words from the input device in a small FIFO and raises InputRecv toward the FSM. The FSM samples InputRecv at the Fetch boundary and enters ExH_B with ExType=0.
- Pops the head word on the FSM's InputRst acknowledge, and presents the head word to the datapath as InputData.

---
 rtl/input_irq_pkg.sv | 6 +
 rtl/input_fifo.sv | 51 +++++
 rtl/input_irq_ctrl.sv | 74 +++++++
 tb/tb_input_irq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/input_irq_pkg.sv
// input_irq_pkg: shared state encoding and default sizing for the input-interrupt feeder.
package input_irq_pkg;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_PENDING, IRQ_ACK_WAIT} irq_state_e;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/input_fifo.sv
// input_fifo: power-of-2 circular buffer with combinational head read; push/pop are self-guarded.
module input_fifo
  import input_irq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic push_ok, pop_ok;
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: the head word is only meaningful while count != 0.
  always_ff @(posedge CLK) mem_q <= mem_d;
endmodule

// File: rtl/input_irq_ctrl.sv
// input_irq_ctrl: buffers device words and raises InputRecv toward the control FSM, popping on the InputRst rising edge.
// Optional sticky overrun flag enabled by defining INPUT_IRQ_OVERRUN_EN.
module input_irq_ctrl
  import input_irq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              dev_valid,
  input  logic [DATA_W-1:0] dev_data,
  output logic              dev_ready,
  input  logic              int_en,
  input  logic              KernelMode,
  input  logic              InputRst,
  output logic              InputRecv,
  output logic [DATA_W-1:0] InputData,
  output logic [CNT_W-1:0]  pending_count,
  output logic              overrun,
  input  logic              overrun_clr
);
  irq_state_e state_q, state_d;
  logic full, empty, pop, input_rst_q, ack_pulse;
  input_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .CLK(CLK),
    .Reset(Reset),
    .push(dev_valid),
    .pop(pop),
    .wdata(dev_data),
    .rdata(InputData),
    .count(pending_count),
    .full(full),
    .empty(empty)
  );
  assign dev_ready = !full;
  assign ack_pulse = InputRst && !input_rst_q;
  assign InputRecv = state_q == IRQ_PENDING;
  // An ack arriving together with a mask/disable still wins, so the handler's word is consumed.
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    case (state_q)
      IRQ_IDLE: state_d = (!empty && int_en && !KernelMode) ? IRQ_PENDING : IRQ_IDLE;
      IRQ_PENDING: begin
        pop = ack_pulse;
        state_d = ack_pulse ? IRQ_ACK_WAIT : (!int_en || KernelMode) ? IRQ_IDLE : IRQ_PENDING;
      end
      IRQ_ACK_WAIT: state_d = (!InputRst && !KernelMode) ? IRQ_IDLE : IRQ_ACK_WAIT;
      default: state_d = IRQ_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IRQ_IDLE;
      input_rst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      input_rst_q <= InputRst;
    end
  end
`ifdef INPUT_IRQ_OVERRUN_EN
  logic overrun_q, overrun_d;
  assign overrun_d = (dev_valid && full) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
  always_ff @(posedge CLK) begin
    if (Reset) overrun_q <= 1'b0;
    else overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0 & overrun_clr;
`endif
endmodule

// File: tb/tb_input_irq_ctrl.sv
// tb_input_irq_ctrl: directed stimulus with a data scoreboard checked by an independent pop monitor.
module tb_input_irq_ctrl;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic dev_valid = 1'b0;
  logic [15:0] dev_data = '0;
  logic dev_ready;
  logic int_en = 1'b0;
  logic KernelMode = 1'b0;
  logic InputRst = 1'b0;
  logic InputRecv;
  logic [15:0] InputData;
  logic [2:0] pending_count;
  logic overrun;
  logic overrun_clr = 1'b0;
  logic prev_rst = 1'b0;
  logic [15:0] exp_q [$];
  int vecs = 0;
  int errs = 0;
`ifdef INPUT_IRQ_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  input_irq_ctrl dut (
    .CLK(CLK),
    .Reset(Reset),
    .dev_valid(dev_valid),
    .dev_data(dev_data),
    .dev_ready(dev_ready),
    .int_en(int_en),
    .KernelMode(KernelMode),
    .InputRst(InputRst),
    .InputRecv(InputRecv),
    .InputData(InputData),
    .pending_count(pending_count),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input bit acc);
    dev_valid = 1'b1;
    dev_data = d;
    if (acc) exp_q.push_back(d);
    cyc(1);
    dev_valid = 1'b0;
  endtask

  task automatic ack();
    InputRst = 1'b1;
    cyc(1);
    InputRst = 1'b0;
    cyc(2);
  endtask

  // Acknowledge-edge model kept by the bench itself
  always @(posedge CLK) prev_rst <= Reset ? 1'b0 : InputRst;

  // Monitor: whenever a pop is about to happen, the head word must match the scoreboard
  always @(negedge CLK) begin
    if (!Reset && InputRecv && InputRst && !prev_rst) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pop_data: got %0h expected none (scoreboard empty)", InputData);
      end else begin
        chk("pop_data", InputData, exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(2);
    Reset = 1'b0;
    chk("rst_recv", InputRecv, 0);
    chk("rst_count", pending_count, 0);
    chk("rst_ready", dev_ready, 1);
    chk("rst_overrun", overrun, 0);
    // first word raises InputRecv one cycle after the push edge
    int_en = 1'b1;
    push_word(16'hA5A5, 1);
    chk("t1_count", pending_count, 1);
    chk("t1_recv_early", InputRecv, 0);
    chk("t1_data", InputData, 16'hA5A5);
    cyc(1);
    chk("t1_recv", InputRecv, 1);
    // held acknowledge pops once; no re-raise until InputRst falls
    InputRst = 1'b1;
    cyc(1);
    chk("t2_count", pending_count, 0);
    chk("t2_recv", InputRecv, 0);
    push_word(16'h0001, 1);
    cyc(1);
    chk("t2_hold_recv", InputRecv, 0);
    chk("t2_hold_count", pending_count, 1);
    InputRst = 1'b0;
    cyc(1);
    chk("t2_idle_recv", InputRecv, 0);
    cyc(1);
    chk("t2_rearm_recv", InputRecv, 1);
    chk("t2_rearm_data", InputData, 16'h0001);
    // fill, overflow, clear, drain in order
    push_word(16'h0002, 1);
    push_word(16'h0003, 1);
    push_word(16'h0004, 1);
    chk("t3_full_count", pending_count, 4);
    chk("t3_full_ready", dev_ready, 0);
    push_word(16'h0005, 0);
    chk("t3_drop_count", pending_count, 4);
    chk("t3_overrun", overrun, OVR_EXP);
    overrun_clr = 1'b1;
    cyc(1);
    overrun_clr = 1'b0;
    chk("t3_overrun_clr", overrun, 0);
    repeat (4) ack();
    chk("t3_drained", pending_count, 0);
    chk("t3_drained_recv", InputRecv, 0);
    // simultaneous push and pop at count 2
    push_word(16'h0010, 1);
    push_word(16'h0020, 1);
    chk("t4_recv", InputRecv, 1);
    chk("t4_count", pending_count, 2);
    dev_valid = 1'b1;
    dev_data = 16'h0030;
    exp_q.push_back(16'h0030);
    InputRst = 1'b1;
    cyc(1);
    dev_valid = 1'b0;
    InputRst = 1'b0;
    chk("t4_count_same", pending_count, 2);
    chk("t4_data_adv", InputData, 16'h0020);
    cyc(2);
    ack();
    ack();
    chk("t4_drained", pending_count, 0);
    // kernel-mode masking and int_en gating
    KernelMode = 1'b1;
    push_word(16'h0040, 1);
    cyc(2);
    chk("t5_km_recv", InputRecv, 0);
    chk("t5_km_count", pending_count, 1);
    KernelMode = 1'b0;
    cyc(1);
    chk("t5_unmask_recv", InputRecv, 1);
    ack();
    int_en = 1'b0;
    push_word(16'h0050, 1);
    cyc(3);
    chk("t5_dis_recv", InputRecv, 0);
    chk("t5_dis_count", pending_count, 1);
    // reset while PENDING with acknowledge high
    int_en = 1'b1;
    push_word(16'h0060, 1);
    push_word(16'h0070, 1);
    chk("t6_recv", InputRecv, 1);
    chk("t6_count", pending_count, 3);
    push_word(16'h0080, 1);
    push_word(16'h0090, 0);
    chk("t6_overrun", overrun, OVR_EXP);
    Reset = 1'b1;
    InputRst = 1'b1;
    cyc(1);
    Reset = 1'b0;
    InputRst = 1'b0;
    exp_q.delete();
    chk("t6_count", pending_count, 0);
    chk("t6_recv_rst", InputRecv, 0);
    chk("t6_ready", dev_ready, 1);
    chk("t6_overrun_rst", overrun, 0);
    cyc(2);
    chk("t6_recv_after", InputRecv, 0);
    chk("leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
